uart_param: RTL and testbench
=============================

# uart_param

Parametrised full-duplex UART, the next generation of the fixed 8N1 `uart` core, for the SIMP peripheral bus. It generalises clock and baud rate, data width and stop-bit count, and adds 16x oversampled reception with glitch rejection, framing/overrun detection and optional parity. The port names and handshake (`din`/`wr_en`/`tx_busy`, `dout`/`rdy`/`rdy_clr`) match `uart`, so existing loopback benches drive it unchanged.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: line rate.
- `DATA_BITS`, 8: data bits per frame, legal 5..8.
- `STOP_BITS`, 1: stop bits transmitted, legal 1..2. Rx always checks exactly one.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even. Used only with `UART_PARITY_EN`.
- `clk_50m` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `din` in DATA_BITS: tx data, sampled when a write is accepted.
- `wr_en` in 1: write strobe.
- `tx` out 1: serial output, idle high.
- `tx_busy` out 1: transmitter occupied.
- `rx` in 1: serial input, asynchronous.
- `rdy` out 1: `dout` holds an unread character.
- `rdy_clr` in 1: clears `rdy` and the error flags.
- `dout` out DATA_BITS: last received character.
- `frame_err` out 1: stop bit of the character in `dout` sampled low.
- `parity_err` out 1: parity mismatch on the character in `dout`.
- `overrun` out 1: sticky; a character arrived while `rdy`=1.

## Operation
- Dividers use truncation: TX_DIV = CLK_HZ/BAUD and RX_DIV = CLK_HZ/(16*BAUD). Both must be at least 1.
- **Tx FSM** states: IDLE, START, DATA, PARITY, STOP.
  - `wr_en`=1 in IDLE: latch `din`, enter START. `tx_busy`=1 from the next cycle.
  - `wr_en` outside IDLE is ignored, with no queueing.
  - Each bit lasts exactly TX_DIV clocks. The bit counter restarts on accept.
  - Data is sent LSB first, then parity if compiled in, then STOP_BITS high bits, then IDLE.
- **Rx path**: `rx` passes through a 2-flop synchroniser. A tick fires every RX_DIV clocks.
- **Rx FSM** states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised low enters START, with the tick counter zeroed.
  - START: resample at 8 ticks. If high, treat it as a glitch and return to IDLE with no flags changed.
  - DATA: sample every 16 ticks, LSB first. Then PARITY if compiled in, then STOP at 16 ticks.
- **Stop sample** completes the character in the same cycle:
  - `rdy`=0 or `rdy_clr`=1: load `dout`, set `rdy`=1, and set `frame_err`/`parity_err` from this character.
  - `rdy`=1 and `rdy_clr`=0: discard the character, set `overrun`=1, and leave `dout` and the flags unchanged.
  - Return to IDLE. A low stop bit still returns to IDLE, then waits for a new falling level.
- `rdy_clr`=1 with no completion in the same cycle: `rdy`, `frame_err`, `parity_err` and `overrun` all go to 0 on the next edge.
- Width rule: when DATA_BITS < 8, Tx and Rx shift only DATA_BITS bits.

## Timing
- **Reset values** (`rst_n`=0 at an edge): `tx`=1, `tx_busy`=0, `rdy`=0, `dout`=0, all error flags 0, both FSMs in IDLE, synchroniser preset high.
- Reset mid-frame aborts immediately: `tx`=1 on the next edge, and no partial character is delivered.
- Tx latency:
  - `tx` falls on the edge after `wr_en` is accepted.
  - Frame length F = TX_DIV*(1+DATA_BITS+P+STOP_BITS) clocks, where P = 1 with parity and 0 otherwise.
  - `tx_busy` falls F clocks after it rose.
  - A new `wr_en` is accepted in the first cycle `tx_busy`=0, allowing back-to-back frames with no gap.
- Rx latency: `rdy` rises 2 (synchroniser) + RX_DIV*(8+16*(DATA_BITS+P+1)) clocks after the `rx` falling edge, within ±1 clock.
- Tx and Rx are fully independent, so simultaneous activity is legal.

## Configuration
- `UART_PARITY_EN` defined:
  - Tx inserts a parity bit after the data bits, using `PARITY_ODD`.
  - Rx expects and checks the parity bit and drives `parity_err`.
- `UART_PARITY_EN` undefined:
  - No parity bit on either side; P = 0.
  - `parity_err` is tied to 0 and the PARITY states are not built.

## Test plan
- Bench uses CLK_HZ=1_600_000, BAUD=100_000 (TX_DIV=16, RX_DIV=1), `tx` looped to `rx`.
- Loopback with DATA_BITS=8, STOP_BITS=1: send 0x00..0xFF, clear `rdy` after each -> every `dout` matches `din`, no flags set, each `tx_busy` pulse lasts 160 clocks.
- Write 0xA5 followed by `wr_en` at clock 40 of that frame -> only 0xA5 is received. With DATA_BITS=5, write 0x3F -> `dout`=0x1F.
- Break the loop, drive a frame of 0x55 with its stop bit low -> `rdy`=1, `dout`=0x55, `frame_err`=1. Drive a 3-clock low pulse on `rx` -> `rdy` stays 0.
- Send 0x11 then 0x22 without `rdy_clr` -> `dout`=0x11, `overrun`=1. Pulse `rdy_clr` -> all flags and `rdy` read 0.
- With `UART_PARITY_EN`, PARITY_ODD=0: send 0x07 -> parity bit 1 seen on `tx`. Inject 0x07 with parity bit 0 -> `parity_err`=1. Assert `rst_n`=0 mid-frame -> `tx`=1 and `tx_busy`=0 on the next edge.

Source files
------------

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART for the SIMP peripheral bus.
//
// Transmit side serialises din as start bit, DATA_BITS data bits LSB first,
// an optional parity bit and STOP_BITS stop bits, each TX_DIV clocks long.
// Receive side synchronises rx, oversamples at 16x the line rate, rejects
// start-bit glitches and reports framing, parity and overrun conditions.
//
// Optional feature macro: UART_PARITY_EN
//   defined   -> parity bit sent and checked (sense chosen by PARITY_ODD)
//   undefined -> no parity bit, parity_err tied low
//
// Ports:
//   clk_50m     in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   din         in   tx data, captured when a write is accepted
//   wr_en       in   write strobe, honoured only while the transmitter is idle
//   tx          out  serial output, idle high
//   tx_busy     out  transmitter occupied
//   rx          in   serial input, asynchronous
//   rdy         out  dout holds an unread character
//   rdy_clr     in   clears rdy and all error flags
//   dout        out  last received character
//   frame_err   out  stop bit of the character in dout was low
//   parity_err  out  parity mismatch on the character in dout
//   overrun     out  sticky: a character arrived while rdy was set
module uart_param #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic                 rdy,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int unsigned TX_DIV = CLK_HZ / BAUD;
    localparam int unsigned RX_DIV = CLK_HZ / (16 * BAUD);
    localparam int unsigned TX_CW  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam int unsigned RX_CW  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

    localparam logic [TX_CW-1:0] TX_LAST   = TX_CW'(TX_DIV - 1);
    localparam logic [RX_CW-1:0] RX_LAST   = RX_CW'(RX_DIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    // Shared state encoding for both FSMs.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Elaboration-time parameter sanity checks.
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_param: DATA_BITS must be in 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_param: PARITY_ODD must be 0 or 1");
    end
    if (TX_DIV < 1 || RX_DIV < 1) begin : g_bad_divider
        $error("uart_param: CLK_HZ too low for 16x oversampling at BAUD");
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [2:0]           tx_state_q, tx_state_d;
    logic [TX_CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif
    logic                 tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == TX_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q != ST_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end

        case (tx_state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (wr_en) begin
                    tx_shift_d = din;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = 1'b0;
                    tx_state_d = ST_START;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^din) ^ (PARITY_ODD != 0);
`endif
                end
            end
            ST_START: begin
                if (tx_bit_end) begin
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d   = '0;
`ifdef UART_PARITY_EN
                        tx_d       = tx_par_q;
                        tx_state_d = ST_PARITY;
`else
                        tx_d       = 1'b1;
                        tx_state_d = ST_STOP;
`endif
                    end else begin
                        // Present the next data bit; shift keeps it at index 1.
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_d       = tx_shift_q[1];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tx_bit_end) begin
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                    tx_state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (tx_bit_end) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = ST_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d       = 1'b1;
                tx_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (tx_state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    // rx_prev_q delays the synchronised line by one more cycle so that IDLE
    // arms only on a high-to-low transition, never on a line held low.
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [RX_CW-1:0]     rx_pre_q, rx_pre_d;
    logic                 rx_tick;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [3:0]           rx_tcnt_q, rx_tcnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_done;
    logic                 rdy_q, rdy_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_PARITY_EN
    logic                 rx_par_q, rx_par_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign rx_tick = (rx_pre_q == RX_LAST);

    always_comb begin
        rx_pre_d   = rx_tick ? '0 : rx_pre_q + 1'b1;
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
`endif

        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_sync_q && rx_prev_q) begin
                    // Restart the prescaler so bit centres align to this edge.
                    rx_pre_d   = '0;
                    rx_tcnt_d  = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_tick) begin
                    if (rx_tcnt_q == 4'd7) begin
                        rx_tcnt_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (rx_tick) begin
                    if (rx_tcnt_q == 4'd15) begin
                        rx_tcnt_d  = '0;
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state_d = ST_PARITY;
`else
                            rx_state_d = ST_STOP;
`endif
                        end else begin
                            rx_bit_d = rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (rx_tick) begin
                    if (rx_tcnt_q == 4'd15) begin
                        rx_tcnt_d  = '0;
                        rx_par_d   = rx_sync_q;
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (rx_tick) begin
                    if (rx_tcnt_q == 4'd15) begin
                        rx_tcnt_d  = '0;
                        rx_done    = 1'b1;
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
            end
        endcase
    end

    // Host-visible status. A character completing in the same cycle as
    // rdy_clr is accepted, so rdy_clr never causes a spurious overrun.
    always_comb begin
        rdy_d        = rdy_q;
        dout_d       = dout_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
`ifdef UART_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (rx_done) begin
            if (!rdy_q || rdy_clr) begin
                rdy_d        = 1'b1;
                dout_d       = rx_shift_q;
                frame_err_d  = !rx_sync_q;
                overrun_d    = rdy_clr ? 1'b0 : overrun_q;
`ifdef UART_PARITY_EN
                parity_err_d = rx_par_q ^ (^rx_shift_q) ^ (PARITY_ODD != 0);
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rdy_clr) begin
            rdy_d        = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
`ifdef UART_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_pre_q     <= '0;
            rx_state_q   <= ST_IDLE;
            rx_tcnt_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rdy_q        <= 1'b0;
            dout_q       <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_pre_q     <= rx_pre_d;
            rx_state_q   <= rx_state_d;
            rx_tcnt_q    <= rx_tcnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rdy_q        <= rdy_d;
            dout_q       <= dout_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_PARITY_EN
            rx_par_q     <= rx_par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rdy       = rdy_q;
    assign dout      = dout_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: an 8N1 instance with tx looped to rx
// (loop can be broken to inject hand-built frames) and a 5-bit, 2-stop-bit
// instance in permanent loopback.
module tb_uart_param;

    localparam int unsigned CLK_HZ  = 1_600_000;
    localparam int unsigned BAUD    = 100_000;
    localparam int          PAR_ODD = 0;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int BIT_CLKS = 16;
    localparam int F8   = BIT_CLKS * (1 + 8 + P + 1);
    localparam int F5   = BIT_CLKS * (1 + 5 + P + 2);
    localparam int LAT8 = 2 + (8 + 16 * (8 + P + 1));
    localparam int LAT5 = 2 + (8 + 16 * (5 + P + 1));

    logic       clk, rst_n;
    logic [7:0] din8, dout8;
    logic       wr_en8, tx8, tx_busy8, rx8, rdy8, rdy_clr8;
    logic       frame_err8, parity_err8, overrun8;
    logic       loop8, rx_drv8;
    logic [4:0] din5, dout5;
    logic       wr_en5, tx5, tx_busy5, rdy5, rdy_clr5;
    logic       frame_err5, parity_err5, overrun5;

    int checks = 0;
    int passed = 0;

    assign rx8 = loop8 ? tx8 : rx_drv8;

    uart_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PAR_ODD)
    ) u_dut8 (
        .clk_50m(clk), .rst_n(rst_n), .din(din8), .wr_en(wr_en8), .tx(tx8),
        .tx_busy(tx_busy8), .rx(rx8), .rdy(rdy8), .rdy_clr(rdy_clr8), .dout(dout8),
        .frame_err(frame_err8), .parity_err(parity_err8), .overrun(overrun8)
    );

    uart_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(PAR_ODD)
    ) u_dut5 (
        .clk_50m(clk), .rst_n(rst_n), .din(din5), .wr_en(wr_en5), .tx(tx5),
        .tx_busy(tx_busy5), .rx(tx5), .rdy(rdy5), .rdy_clr(rdy_clr5), .dout(dout5),
        .frame_err(frame_err5), .parity_err(parity_err5), .overrun(overrun5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Parity bit value for the low n bits of d.
    function automatic logic par_of(input logic [7:0] d, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(d[i]);
        return ((ones % 2) == 1) ^ (PAR_ODD != 0);
    endfunction

    // Expected line levels, one entry per bit period; unused tail reads 1.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int n, input int ns);
        logic [15:0] f;
        int pos;
        f = '1;
        f[0] = 1'b0;
        pos = 1;
        for (int i = 0; i < n; i++) begin
            f[pos] = d[i];
            pos++;
        end
        if (P != 0) begin
            f[pos] = par_of(d, n);
            pos++;
        end
        for (int i = 0; i < ns; i++) begin
            f[pos] = 1'b1;
            pos++;
        end
        return f;
    endfunction

    // One write on the 8-bit instance; collects the tx waveform at bit centres.
    task automatic frame8(input logic [7:0] d, input bit auto_clr, input bit intrude,
                          input logic [7:0] d2);
        int busy, lat;
        bit got;
        logic [15:0] obs;
        logic [7:0] got_dout;
        logic [2:0] got_flags;
        busy = 0; lat = -1; got = 0; obs = '1; got_dout = '0; got_flags = '0;
        din8 = d; wr_en8 = 1'b1;
        tick();
        wr_en8 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!tx_busy8) break;
            busy++;
            if (c % 16 == 8 && c < 256) obs[c/16] = tx8;
            wr_en8 = 1'b0;
            if (intrude && c == 40) begin
                din8 = d2;
                wr_en8 = 1'b1;
            end
            rdy_clr8 = 1'b0;
            if (rdy8 && !got) begin
                got = 1; lat = c; got_dout = dout8;
                got_flags = {frame_err8, parity_err8, overrun8};
                rdy_clr8 = auto_clr;
            end
            tick();
        end
        wr_en8 = 1'b0; rdy_clr8 = 1'b0;
        checks++;
        if (busy != F8) $display("FAIL tx_busy_len8 d=%h: got %0d expected %0d", d, busy, F8);
        else passed++;
        checks++;
        if (obs !== frame_bits(d, 8, 1))
            $display("FAIL tx_wave8 d=%h: got %b expected %b", d, obs, frame_bits(d, 8, 1));
        else passed++;
        if (auto_clr) begin
            checks++;
            if (lat < LAT8 - 1 || lat > LAT8 + 1)
                $display("FAIL rx_latency8 d=%h: got %0d expected %0d+-1", d, lat, LAT8);
            else passed++;
            checks++;
            if (got_dout !== d) $display("FAIL rx_dout8: got %h expected %h", got_dout, d);
            else passed++;
            checks++;
            if (got_flags !== 3'b000)
                $display("FAIL rx_flags8 d=%h: got %b expected 000", d, got_flags);
            else passed++;
        end
    endtask

    task automatic frame5(input logic [4:0] d, input logic [4:0] exp_d);
        int busy, lat;
        bit got;
        logic [15:0] obs;
        logic [4:0] got_dout;
        busy = 0; lat = -1; got = 0; obs = '1; got_dout = '0;
        din5 = d; wr_en5 = 1'b1;
        tick();
        wr_en5 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!tx_busy5) break;
            busy++;
            if (c % 16 == 8 && c < 256) obs[c/16] = tx5;
            rdy_clr5 = 1'b0;
            if (rdy5 && !got) begin
                got = 1; lat = c; got_dout = dout5; rdy_clr5 = 1'b1;
            end
            tick();
        end
        rdy_clr5 = 1'b0;
        checks++;
        if (busy != F5) $display("FAIL tx_busy_len5: got %0d expected %0d", busy, F5);
        else passed++;
        checks++;
        if (obs !== frame_bits({3'b000, d}, 5, 2))
            $display("FAIL tx_wave5: got %b expected %b", obs, frame_bits({3'b000, d}, 5, 2));
        else passed++;
        checks++;
        if (lat < LAT5 - 1 || lat > LAT5 + 1)
            $display("FAIL rx_latency5: got %0d expected %0d+-1", lat, LAT5);
        else passed++;
        checks++;
        if (got_dout !== exp_d) $display("FAIL rx_dout5: got %h expected %h", got_dout, exp_d);
        else passed++;
    endtask

    // Hand-built frame on the 8-bit instance's rx with the loop broken.
    task automatic drive_frame8(input logic [7:0] d, input logic par, input logic stop);
        rx_drv8 = 1'b0;
        repeat (BIT_CLKS) tick();
        for (int i = 0; i < 8; i++) begin
            rx_drv8 = d[i];
            repeat (BIT_CLKS) tick();
        end
        if (P != 0) begin
            rx_drv8 = par;
            repeat (BIT_CLKS) tick();
        end
        rx_drv8 = stop;
        repeat (BIT_CLKS) tick();
        rx_drv8 = 1'b1;
        repeat (48) tick();
    endtask

    task automatic clear8();
        rdy_clr8 = 1'b1;
        tick();
        rdy_clr8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({tx8, tx_busy8, rdy8, frame_err8, parity_err8, overrun8} !== 6'b100000)
            $display("FAIL reset_flags8: got %b expected 100000",
                     {tx8, tx_busy8, rdy8, frame_err8, parity_err8, overrun8});
        else passed++;
        checks++;
        if (dout8 !== 8'h00) $display("FAIL reset_dout8: got %h expected 00", dout8);
        else passed++;
        checks++;
        if ({tx5, tx_busy5, rdy5, frame_err5, parity_err5, overrun5} !== 6'b100000)
            $display("FAIL reset_flags5: got %b expected 100000",
                     {tx5, tx_busy5, rdy5, frame_err5, parity_err5, overrun5});
        else passed++;
        checks++;
        if (dout5 !== 5'h00) $display("FAIL reset_dout5: got %h expected 00", dout5);
        else passed++;
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    // All 256 values back to back: each write issued in the first idle cycle.
    task automatic test_loopback_sweep();
        for (int v = 0; v < 256; v++) frame8(8'(v), 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_ignore_busy_write();
        logic [7:0] d2;
        bit saw_busy, saw_rdy;
        d2 = 8'($urandom);
        frame8(8'hA5, 1'b1, 1'b1, d2);
        saw_busy = 0; saw_rdy = 0;
        repeat (200) begin
            if (tx_busy8) saw_busy = 1;
            if (rdy8) saw_rdy = 1;
            tick();
        end
        checks++;
        if (saw_busy) $display("FAIL ignored_write_busy: got 1 expected 0");
        else passed++;
        checks++;
        if (saw_rdy) $display("FAIL ignored_write_rdy: got 1 expected 0");
        else passed++;
    endtask

    task automatic test_width5();
        logic [7:0] wide;
        logic [4:0] v;
        wide = 8'h3F;
        frame5(wide[4:0], 5'h1F);
        for (int i = 0; i < 4; i++) begin
            v = 5'($urandom);
            frame5(v, v);
        end
    endtask

    task automatic test_frame_error();
        loop8 = 1'b0; rx_drv8 = 1'b1;
        repeat (8) tick();
        drive_frame8(8'h55, par_of(8'h55, 8), 1'b0);
        checks++;
        if ({rdy8, frame_err8, overrun8} !== 3'b110)
            $display("FAIL frame_err_flags: got %b expected 110", {rdy8, frame_err8, overrun8});
        else passed++;
        checks++;
        if (dout8 !== 8'h55) $display("FAIL frame_err_dout: got %h expected 55", dout8);
        else passed++;
        clear8();
        checks++;
        if ({rdy8, frame_err8} !== 2'b00)
            $display("FAIL frame_err_clear: got %b expected 00", {rdy8, frame_err8});
        else passed++;
    endtask

    task automatic test_glitch();
        logic [7:0] r;
        rx_drv8 = 1'b0;
        repeat (3) tick();
        rx_drv8 = 1'b1;
        repeat (200) tick();
        checks++;
        if ({rdy8, frame_err8} !== 2'b00)
            $display("FAIL glitch_rejected: got %b expected 00", {rdy8, frame_err8});
        else passed++;
        r = 8'($urandom);
        drive_frame8(r, par_of(r, 8), 1'b1);
        checks++;
        if ({rdy8, frame_err8, parity_err8, dout8} !== {3'b100, r})
            $display("FAIL after_glitch_rx: got %b/%h expected 100/%h",
                     {rdy8, frame_err8, parity_err8}, dout8, r);
        else passed++;
        clear8();
        loop8 = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_overrun();
        frame8(8'h11, 1'b0, 1'b0, 8'h00);
        frame8(8'h22, 1'b0, 1'b0, 8'h00);
        repeat (20) tick();
        checks++;
        if ({rdy8, overrun8, frame_err8} !== 3'b110)
            $display("FAIL overrun_flags: got %b expected 110", {rdy8, overrun8, frame_err8});
        else passed++;
        checks++;
        if (dout8 !== 8'h11) $display("FAIL overrun_dout: got %h expected 11", dout8);
        else passed++;
        clear8();
        checks++;
        if ({rdy8, frame_err8, parity_err8, overrun8} !== 4'b0000)
            $display("FAIL overrun_clear: got %b expected 0000",
                     {rdy8, frame_err8, parity_err8, overrun8});
        else passed++;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        din8 = 8'h07; wr_en8 = 1'b1;
        tick();
        wr_en8 = 1'b0;
        repeat (BIT_CLKS * 9 + 8) tick();
        checks++;
        if (tx8 !== par_of(8'h07, 8))
            $display("FAIL parity_bit_tx: got %b expected %b", tx8, par_of(8'h07, 8));
        else passed++;
        for (int c = 0; c < 300 && tx_busy8; c++) tick();
        checks++;
        if ({rdy8, parity_err8, dout8} !== {2'b10, 8'h07})
            $display("FAIL parity_good_rx: got %b/%h expected 10/07", {rdy8, parity_err8}, dout8);
        else passed++;
        clear8();
        loop8 = 1'b0; rx_drv8 = 1'b1;
        repeat (8) tick();
        drive_frame8(8'h07, 1'b0, 1'b1);
        checks++;
        if ({rdy8, parity_err8, frame_err8} !== 3'b110)
            $display("FAIL parity_err_flag: got %b expected 110", {rdy8, parity_err8, frame_err8});
        else passed++;
        clear8();
        loop8 = 1'b1;
        repeat (4) tick();
    endtask
`endif

    task automatic test_reset_midframe();
        din8 = 8'($urandom); wr_en8 = 1'b1;
        tick();
        wr_en8 = 1'b0;
        repeat (50) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({tx8, tx_busy8} !== 2'b10)
            $display("FAIL reset_midframe_tx: got %b expected 10", {tx8, tx_busy8});
        else passed++;
        rst_n = 1'b1;
        repeat (250) tick();
        checks++;
        if ({rdy8, tx_busy8} !== 2'b00)
            $display("FAIL reset_midframe_rx: got %b expected 00", {rdy8, tx_busy8});
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        din8 = '0; wr_en8 = 1'b0; rdy_clr8 = 1'b0; loop8 = 1'b1; rx_drv8 = 1'b1;
        din5 = '0; wr_en5 = 1'b0; rdy_clr5 = 1'b0;
        test_reset();
        test_loopback_sweep();
        test_ignore_busy_write();
        test_width5();
        test_frame_error();
        test_glitch();
        test_overrun();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
